// File: rtl/ex2_pkg.sv
// Shared defaults, result entry layout and sizing helper for the ex2 result path.
package ex2_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_CNT_W = 16;

    // One buffered result: payload plus end-of-burst marker.
    typedef struct packed {
        logic                 last;
        logic [DEF_WIDTH-1:0] data;
    } result_entry_t;

    // Occupancy counter width able to represent 0..depth inclusive.
    function automatic int unsigned lvl_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ex2_sync_fifo.sv
// Generic circular-buffer FIFO with push/pop, occupancy and head presentation.
// Head data reads as zero while empty; a push into a full buffer is only
// accepted when a pop frees the head slot in the same cycle.
module ex2_sync_fifo
    import ex2_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_WIDTH + 1,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_push,
    input  logic [DATA_W-1:0]         i_data,
    input  logic                      i_pop,
    output logic                      o_valid_c,
    output logic                      o_full_c,
    output logic [DATA_W-1:0]         o_head_c,
    output logic [lvl_w(DEPTH)-1:0]   o_level
);

    localparam int unsigned LVL_W = lvl_w(DEPTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [LVL_W-1:0]  r_level;

    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    // Occupancy decode and handshake qualification.
    always_comb begin
        w_valid = (r_level != '0);
        w_full  = (r_level == LVL_W'(DEPTH));
        w_pop   = i_pop & w_valid;
        w_push  = i_push & (~w_full | w_pop);
    end

    // Storage array; written only on an accepted push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Level moves only when exactly one of push/pop happens.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_valid_c = w_valid;
    assign o_full_c  = w_full;
    assign o_head_c  = w_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level   = r_level;

endmodule

// File: rtl/ex2_result_fifo.sv
// Downstream stage of the a*b+c stream unit: tags the final result of each
// contiguous burst, buffers results for a valid/ready consumer and counts
// results lost to overflow (the upstream stream cannot be stalled).
module ex2_result_fifo
    import ex2_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [lvl_w(DEPTH)-1:0] level,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    overflow
);

    localparam int unsigned LVL_W   = lvl_w(DEPTH);
    localparam int unsigned ENTRY_W = WIDTH + 1;

    // Same layout as result_entry_t, sized by this instance's WIDTH.
    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic             r_hold_full;
    logic [WIDTH-1:0] r_hold_data;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_overflow;

    entry_t           w_push_entry;
    entry_t           w_head;
    logic             w_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_drop;
    logic [LVL_W-1:0] w_level;

    // Held sample is the last of its burst when no new sample follows it.
    always_comb begin
        w_push_entry.last = ~in_valid;
        w_push_entry.data = r_hold_data;
        w_pop             = w_valid & out_ready;
        w_drop            = r_hold_full & w_full & ~w_pop;
    end

    // One-deep hold stage: delays each sample a cycle so its last bit is known.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
        end else begin
            r_hold_full <= in_valid;
            if (in_valid) begin
                r_hold_data <= in_data;
            end
        end
    end

    // Saturating drop counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    ex2_sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (r_hold_full),
        .i_data    (w_push_entry),
        .i_pop     (out_ready),
        .o_valid_c (w_valid),
        .o_full_c  (w_full),
        .o_head_c  (w_head),
        .o_level   (w_level)
    );

    assign out_valid = w_valid;
    assign out_data  = w_head.data;
    assign out_last  = w_head.last;
    assign level     = w_level;
    assign drop_cnt  = r_drop_cnt;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ex2_result_fifo.sv
// Directed bench for ex2_result_fifo: default instance plus a 4-bit drop
// counter instance sharing the same stimulus.
module tb_ex2_result_fifo;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic [2:0]  level;
    logic [15:0] drop_cnt;
    logic        overflow;

    logic        s_out_valid;
    logic [31:0] s_out_data;
    logic        s_out_last;
    logic [2:0]  s_level;
    logic [3:0]  s_drop_cnt;
    logic        s_overflow;

    int n_assert;
    int n_fail;

    ex2_result_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .level     (level),
        .drop_cnt  (drop_cnt),
        .overflow  (overflow)
    );

    ex2_result_fifo #(.CNT_W(4)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (s_out_valid),
        .out_data  (s_out_data),
        .out_last  (s_out_last),
        .level     (s_level),
        .drop_cnt  (s_drop_cnt),
        .overflow  (s_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        do_reset();

        // Single result: visible two cycles after presentation, for one cycle.
        in_valid = 1'b1; in_data = 32'h7; out_ready = 1'b1;
        tick();
        chk("single_early", 64'(out_valid), 64'd0);
        in_valid = 1'b0;
        tick();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data", 64'(out_data), 64'h7);
        chk("single_last", 64'(out_last), 64'd1);
        chk("single_level", 64'(level), 64'd1);
        tick();
        chk("single_gone", 64'(out_valid), 64'd0);

        // Burst of three with consumer always ready.
        in_valid = 1'b1; in_data = 32'h10;
        tick();
        in_data = 32'h11;
        tick();
        chk("burst0_data", 64'(out_data), 64'h10);
        chk("burst0_last", 64'(out_last), 64'd0);
        in_data = 32'h12;
        tick();
        chk("burst1_data", 64'(out_data), 64'h11);
        chk("burst1_last", 64'(out_last), 64'd0);
        in_valid = 1'b0;
        tick();
        chk("burst2_data", 64'(out_data), 64'h12);
        chk("burst2_last", 64'(out_last), 64'd1);
        tick();
        chk("burst_empty", 64'(out_valid), 64'd0);
        chk("burst_level", 64'(level), 64'd0);

        // Fill to full, then stream with simultaneous push and pop.
        for (int c = 0; c < 16; c++) begin
            if (c == 5) chk("fp_full_level", 64'(level), 64'd4);
            if (c >= 5 && c <= 14) begin
                chk("fp_data", 64'(out_data), 64'(32'h20 + c - 5));
                chk("fp_last", 64'(out_last), 64'(c == 14));
                chk("fp_level", 64'(level), (c <= 11) ? 64'd4 : 64'(15 - c));
            end
            if (c == 15) chk("fp_drained", 64'(out_valid), 64'd0);
            in_valid  = (c <= 9);
            in_data   = 32'h20 + 32'(c);
            out_ready = (c >= 5);
            tick();
        end
        chk("fp_no_drop", 64'(drop_cnt), 64'd0);
        chk("fp_no_ovf", 64'(overflow), 64'd0);

        // Overflow under backpressure: 6 samples into 4 entries.
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 6);
            in_data  = 32'(c + 1);
            tick();
        end
        chk("ovf_level", 64'(level), 64'd4);
        chk("ovf_drop", 64'(drop_cnt), 64'd2);
        chk("ovf_flag", 64'(overflow), 64'd1);
        tick();
        chk("ovf_stable_data", 64'(out_data), 64'd1);
        chk("ovf_stable_drop", 64'(drop_cnt), 64'd2);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_drain_data", 64'(out_data), 64'(i));
            chk("ovf_drain_last", 64'(out_last), 64'd0);
            tick();
        end
        chk("ovf_drain_empty", 64'(out_valid), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Asynchronous reset mid-burst.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h30;
        tick();
        in_data = 32'h31;
        tick();
        chk("mid_pre_valid", 64'(out_valid), 64'd1);
        chk("mid_pre_data", 64'(out_data), 64'h30);
        in_data = 32'h32;
        #2 rst = 1'b0;
        #1;
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_data", 64'(out_data), 64'd0);
        chk("mid_last", 64'(out_last), 64'd0);
        chk("mid_level", 64'(level), 64'd0);
        chk("mid_drop", 64'(drop_cnt), 64'd0);
        chk("mid_ovf", 64'(overflow), 64'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        in_valid = 1'b1; in_data = 32'hAB; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("post_early", 64'(out_valid), 64'd0);
        tick();
        chk("post_data", 64'(out_data), 64'hAB);
        chk("post_last", 64'(out_last), 64'd1);
        chk("post_level", 64'(level), 64'd1);
        tick();
        chk("post_alone", 64'(out_valid), 64'd0);

        // Drop counter saturation on the 4-bit instance.
        do_reset();
        for (int c = 0; c < 27; c++) begin
            if (c == 20) begin
                chk("sat_reach", 64'(s_drop_cnt), 64'd15);
                chk("sat_wide_mid", 64'(drop_cnt), 64'd15);
            end
            in_valid = (c < 25);
            in_data  = 32'(c);
            tick();
        end
        chk("sat_hold", 64'(s_drop_cnt), 64'd15);
        chk("sat_ovf", 64'(s_overflow), 64'd1);
        chk("sat_level", 64'(s_level), 64'd4);
        chk("sat_wide", 64'(drop_cnt), 64'd21);
        chk("sat_head", 64'(s_out_data), 64'd0);
        chk("sat_head_valid", 64'(s_out_valid), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex2_result_fifo.md
Name: ex2_result_fifo

Overview:
- Downstream stage of the a*b+c stream unit. Consumes its valido/data_out result stream, which has no backpressure.
- Marks the final result of each contiguous burst with a last flag.
- Buffers results in a small FIFO and presents them on a valid/ready output handshake.
- Counts results lost when the buffer overflows.

Parameters:
- WIDTH, 32, data width of results.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; state is cleared while rst=0.
- in_valid  input  1  upstream result valid (connects to valido).
- in_data  input  WIDTH  upstream result (connects to data_out).
- out_ready  input  1  consumer accepts the head entry this cycle.
- out_valid  output  1  head entry present.
- out_data  output  WIDTH  head entry data.
- out_last  output  1  head entry is the last result of its burst.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  output  CNT_W  number of dropped results, saturating.
- overflow  output  1  sticky flag, set on the first drop.

Behaviour:
- Reset, while rst=0 and independent of clk:
  - out_valid=0, out_data=0, out_last=0, level=0, drop_cnt=0, overflow=0.
  - hold register empty; read/write pointers = 0.
- Hold stage:
  - Any cycle with in_valid=1 captures in_data into hold_data and sets hold_full=1.
  - On each edge with hold_full=1, the held sample is pushed with last = ~in_valid.
  - Sample-and-push example: if in_valid=1 in both cycle k and cycle k+1, the edge ending k+1 pushes the cycle-k sample with last=0 and simultaneously loads the cycle-k+1 sample into hold.
  - If in_valid=0, the held sample is pushed with last=1 and hold_full clears.
  - Every sample is pushed exactly once.
- Latency: a sample presented in cycle k appears at the FIFO head no earlier than cycle k+2 (FIFO empty, no backpressure).
- FIFO:
  - Entry = {data, last}; circular buffer with wrapping pointers.
  - Outputs are driven from the head entry. out_data and out_last are 0 when empty.
  - out_valid = (level != 0).
  - Pop when out_valid & out_ready.
  - Push when a hold push occurs and (level < DEPTH or a pop happens the same cycle).
  - Push and pop in the same cycle when full: both happen, level unchanged.
  - Push and pop in the same cycle when empty: impossible, since a push is not visible until the next cycle.
- Overflow:
  - A hold push with level == DEPTH and no pop is dropped; the entry is discarded.
  - The drop increments drop_cnt, saturating at 2^CNT_W-1, and sets overflow=1.
  - overflow is sticky until reset. FIFO contents are unaffected.
- A dropped last=1 entry is lost; the preceding stored entry is not relabelled.
- out_valid/out_data/out_last stay stable while out_valid=1 and out_ready=0.
- Reset mid-burst discards the hold register and FIFO contents. After rst deasserts, the first in_valid starts a new burst.
- Arithmetic: level increments on push-only, decrements on pop-only, otherwise unchanged; never exceeds DEPTH.

Decomposition:
- Package ex2_pkg:
  - WIDTH default constant.
  - packed struct result_entry_t {logic last; logic [WIDTH-1:0] data}.
- One sub-module is natural: ex2_sync_fifo.
  - Generic DEPTH x entry circular buffer with push/pop/level.
  - Same clk and active-low async rst.
- Hold stage, drop counter and overflow flag live in ex2_result_fifo.

Test Plan:
- Single result: in_valid=1 one cycle with in_data=0x0000_0007, out_ready=1 -> out_valid=1 for exactly one cycle, two cycles later, out_data=7, out_last=1.
- Burst of 3 (0x10, 0x11, 0x12), out_ready=1 -> three consecutive outputs 0x10/last=0, 0x11/last=0, 0x12/last=1; level returns to 0.
- Backpressure overflow: out_ready=0, DEPTH=4, burst of 6 values 1..6 -> level=4, FIFO holds 1..4, drop_cnt=2, overflow=1. Then out_ready=1 drains 1,2,3,4 with all last=0.
- Full with simultaneous pop: fill to 4, then continuous in_valid with out_ready=1 -> level stays 4, drop_cnt stays 0, data is output in order.
- Reset mid-burst: after 2 of 4 samples, pulse rst=0 asynchronously between edges -> all outputs 0 immediately. A post-reset single sample 0xAB emerges alone with last=1.
- Saturation: CNT_W=4, out_ready=0, 25 samples into DEPTH=4 -> drop_cnt=15, held at 15, overflow=1.
